// File: rtl/imu_spi_reader.sv
// SPI master that reads accelerometer, gyro and magnetometer X/Y/Z words in turn
// on each accepted sample_tick and streams them out as nine id-tagged 16-bit samples.
module imu_spi_reader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        configured,
  input  logic        sample_tick,
  input  logic [7:0]  acc_add,
  input  logic [7:0]  gyro_add,
  input  logic [7:0]  mag_add,
  input  logic        sensor_miso,
  output logic        sensor_sclk,
  output logic        sensor_mosi,
  output logic [2:0]  sensor_ss_n,
  output logic [15:0] sample_data,
  output logic [3:0]  sample_id,
  output logic        sample_valid,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("imu_spi_reader: CLK_DIV out of range 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST  = 6'd55;
  localparam logic [5:0] CMD_BITS  = 6'd8;
  localparam logic [1:0] SENS_ACC  = 2'd0;
  localparam logic [1:0] SENS_GYRO = 2'd1;
  localparam logic [1:0] SENS_MAG  = 2'd2;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_div;
  logic [5:0]  r_bit;
  logic        r_phase;
  logic [1:0]  r_sensor;
  logic [7:0]  r_acc_add;
  logic [7:0]  r_gyro_add;
  logic [7:0]  r_mag_add;
  logic [14:0] r_shift;
  logic [15:0] r_sample_data;
  logic [3:0]  r_sample_id;
  logic        r_sample_valid;
  logic        r_frame_done;
  logic        r_overrun;

  logic        w_start;
  logic        w_div_last;
  logic        w_bit_end;
  logic        w_word_end;
  logic [1:0]  w_axis;
  logic [7:0]  w_cmd;
  logic [2:0]  w_sel_n;

  assign w_start    = sample_tick && configured;
  assign w_div_last = (r_div == DIV_LAST);
  assign w_bit_end  = w_div_last && r_phase;

  always_comb begin
    w_cmd = r_mag_add;
    case (r_sensor)
      SENS_ACC:  w_cmd = r_acc_add;
      SENS_GYRO: w_cmd = r_gyro_add;
      default:   w_cmd = r_mag_add;
    endcase
  end

  // Read bits 8..23 are X, 24..39 Y, 40..55 Z; a word completes on its last bit.
  always_comb begin
    w_word_end = 1'b0;
    w_axis     = 2'd0;
    case (r_bit)
      6'd23: begin w_word_end = 1'b1; w_axis = 2'd0; end
      6'd39: begin w_word_end = 1'b1; w_axis = 2'd1; end
      6'd55: begin w_word_end = 1'b1; w_axis = 2'd2; end
      default: begin w_word_end = 1'b0; w_axis = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (w_div_last) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_bit_end && (r_bit == BIT_LAST)) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_div_last) w_next = (r_sensor == SENS_MAG) ? S_IDLE : S_SETUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div          <= '0;
      r_bit          <= '0;
      r_phase        <= 1'b0;
      r_sensor       <= SENS_ACC;
      r_acc_add      <= '0;
      r_gyro_add     <= '0;
      r_mag_add      <= '0;
      r_shift        <= '0;
      r_sample_data  <= '0;
      r_sample_id    <= '0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= sample_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_div   <= '0;
          r_bit   <= '0;
          r_phase <= 1'b0;
          if (w_start) begin
            r_acc_add  <= acc_add;
            r_gyro_add <= gyro_add;
            r_mag_add  <= mag_add;
            r_sensor   <= SENS_ACC;
          end
        end
        S_SETUP: begin
          r_div <= w_div_last ? '0 : r_div + 8'd1;
        end
        S_SHIFT: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_phase) begin
              r_phase <= 1'b0;
              r_bit   <= (r_bit == BIT_LAST) ? '0 : r_bit + 6'd1;
              if (r_bit >= CMD_BITS) begin
                r_shift <= {r_shift[13:0], sensor_miso};
                if (w_word_end) begin
                  r_sample_valid <= 1'b1;
                  r_sample_data  <= {r_shift, sensor_miso};
                  r_sample_id    <= ({2'b00, r_sensor} * 4'd3) + {2'b00, w_axis};
                end
              end
            end else begin
              r_phase <= 1'b1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_GAP: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_sensor == SENS_MAG) begin
              r_frame_done <= 1'b1;
            end else begin
              r_sensor <= r_sensor + 2'd1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: begin
          r_div   <= '0;
          r_bit   <= '0;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

  assign w_sel_n = ~(3'b001 << r_sensor);

  always_comb begin
    busy        = (r_state != S_IDLE);
    sensor_ss_n = '1;
    sensor_mosi = 1'b0;
    case (r_state)
      S_SETUP: begin
        sensor_ss_n = w_sel_n;
        sensor_mosi = w_cmd[7];
      end
      S_SHIFT: begin
        sensor_ss_n = w_sel_n;
        sensor_mosi = (r_bit < CMD_BITS) ? w_cmd[~r_bit[2:0]] : 1'b0;
      end
      default: begin
        sensor_ss_n = '1;
        sensor_mosi = 1'b0;
      end
    endcase
  end

  assign sensor_sclk  = r_phase;
  assign sample_data  = r_sample_data;
  assign sample_id    = r_sample_id;
  assign sample_valid = r_sample_valid;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_imu_spi_reader.sv
// Directed bench for imu_spi_reader: SPI slave model returning fixed words, strobe/overrun
// monitors, and frame timing measured from the accepting clock edge.
`timescale 1ns/1ps
module tb_imu_spi_reader;

  localparam int unsigned D = 2;
  localparam int HALF = 5;
  localparam int FRAME_CYC = 1 + 3 * (D + 112 * D + D);

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        configured = 1'b0;
  logic        sample_tick = 1'b0;
  logic [7:0]  acc_add = 8'h55;
  logic [7:0]  gyro_add = 8'h0F;
  logic [7:0]  mag_add = 8'h81;
  logic        sensor_miso;
  logic        sensor_sclk;
  logic        sensor_mosi;
  logic [2:0]  sensor_ss_n;
  logic [15:0] sample_data;
  logic [3:0]  sample_id;
  logic        sample_valid;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  always #HALF clk = ~clk;

  imu_spi_reader #(.CLK_DIV(D)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .configured   (configured),
    .sample_tick  (sample_tick),
    .acc_add      (acc_add),
    .gyro_add     (gyro_add),
    .mag_add      (mag_add),
    .sensor_miso  (sensor_miso),
    .sensor_sclk  (sensor_sclk),
    .sensor_mosi  (sensor_mosi),
    .sensor_ss_n  (sensor_ss_n),
    .sample_data  (sample_data),
    .sample_id    (sample_id),
    .sample_valid (sample_valid),
    .frame_done   (frame_done),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Word returned by sensor s for axis a is words[s*3+a].
  logic [15:0] words [9] = '{16'h0F0F, 16'hA5A5, 16'h5E0D,
                             16'hA5A5, 16'h5E0D, 16'h0F0F,
                             16'h5E0D, 16'h0F0F, 16'hA5A5};

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] data_q [$];
  logic [3:0]  id_q [$];
  logic [7:0]  cmd_q [$];
  int ovr_cnt  = 0;
  int done_cnt = 0;
  int sel_cnt  = 0;
  time t_acc;
  time t_seen;

  always @(negedge clk) begin
    if (sample_valid) begin
      data_q.push_back(sample_data);
      id_q.push_back(sample_id);
    end
    if (overrun) ovr_cnt++;
    if (frame_done) done_cnt++;
  end

  // SPI mode-0 slave: miso updated on sclk fall (first bit on select), mosi captured on rise.
  logic        w_sel_none;
  logic        prev_sclk = 1'b0;
  logic        prev_none = 1'b1;
  int          s_bit = 0;
  int          s_sens = 0;
  logic [7:0]  cap = '0;
  logic [47:0] payload = '0;
  assign w_sel_none = &sensor_ss_n;

  always @(posedge sensor_sclk or negedge sensor_sclk or posedge w_sel_none or negedge w_sel_none) begin
    if (w_sel_none) begin
      sensor_miso = 1'b0;
    end else if (prev_none) begin
      sel_cnt++;
      s_bit  = 0;
      s_sens = !sensor_ss_n[0] ? 0 : (!sensor_ss_n[1] ? 1 : 2);
      payload = {words[s_sens*3], words[s_sens*3+1], words[s_sens*3+2]};
      sensor_miso = 1'b1;
    end else if (sensor_sclk && !prev_sclk) begin
      if (s_bit < 8) cap = {cap[6:0], sensor_mosi};
      s_bit++;
      if (s_bit == 8) cmd_q.push_back(cap);
    end else if (!sensor_sclk && prev_sclk) begin
      if (s_bit >= 8 && s_bit < 56) sensor_miso = payload[55 - s_bit];
      else sensor_miso = 1'b1;
    end
    prev_sclk = sensor_sclk;
    prev_none = w_sel_none;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    sample_tick = 1'b1;
    t_acc = $time + HALF;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        t_seen = $time;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  function automatic int frame_cycles(input time ta, input time td);
    return int'((td - ta - HALF) / (2 * HALF)) + 1;
  endfunction

  task automatic check_frame(input string tag, input int cb, input int db, input logic [7:0] acc_exp);
    logic [7:0] exp_cmd [3];
    exp_cmd = '{acc_exp, 8'h0F, 8'h81};
    check({tag, "_cmd_count"}, 32'(cmd_q.size() - cb), 32'd3);
    check({tag, "_strobe_count"}, 32'(data_q.size() - db), 32'd9);
    if (cmd_q.size() >= cb + 3)
      for (int k = 0; k < 3; k++) check({tag, "_cmd_byte"}, 32'(cmd_q[cb+k]), 32'(exp_cmd[k]));
    if (data_q.size() >= db + 9)
      for (int k = 0; k < 9; k++) begin
        check({tag, "_id"}, 32'(id_q[db+k]), 32'(k));
        check({tag, "_data"}, 32'(data_q[db+k]), 32'(words[k]));
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, 32'(sensor_sclk), 32'd0);
    check({tag, "_mosi"}, 32'(sensor_mosi), 32'd0);
    check({tag, "_ss_n"}, 32'(sensor_ss_n), 32'h7);
    check({tag, "_data"}, 32'(sample_data), 32'd0);
    check({tag, "_id"}, 32'(sample_id), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int cb, db, ob, fb, sb;
    bit ok;

    #13;
    check_reset_outputs("por");
    #10 n_rst = 1'b1;
    configured = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: asynchronous reset in the middle of SHIFT, after two words are out.
    db = data_q.size();
    start_frame();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (data_q.size() >= db + 2) begin ok = 1'b1; break; end
    end
    check("t1_two_strobes", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_sclk_active_busy", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("t1_rst");
    #14 n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_post_busy", 32'(busy), 32'd0);
    check("t1_post_ss_n", 32'(sensor_ss_n), 32'h7);

    // Test 2: single frame, data, commands and frame length.
    cb = cmd_q.size(); db = data_q.size(); ob = ovr_cnt; fb = done_cnt;
    start_frame();
    wait_frame_done("t2");
    check("t2_frame_cycles", 32'(frame_cycles(t_acc, t_seen)), 32'(FRAME_CYC));
    check_frame("t2", cb, db, 8'h55);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_overrun_none", 32'(ovr_cnt - ob), 32'd0);

    // Test 3: ticks while busy (one in SHIFT, one in the acc GAP).
    cb = cmd_q.size(); db = data_q.size(); ob = ovr_cnt; fb = done_cnt;
    start_frame();
    repeat (40) @(negedge clk);
    pulse_tick();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy && w_sel_none) begin ok = 1'b1; break; end
    end
    check("t3_gap_found", 32'(ok), 32'd1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_frame_done("t3");
    check("t3_frame_cycles", 32'(frame_cycles(t_acc, t_seen)), 32'(FRAME_CYC));
    check_frame("t3", cb, db, 8'h55);
    repeat (20) @(negedge clk);
    check("t3_overrun_count", 32'(ovr_cnt - ob), 32'd2);
    check("t3_one_frame", 32'(done_cnt - fb), 32'd1);
    check("t3_idle_after", 32'(busy), 32'd0);

    // Test 4: configured gating.
    configured = 1'b0;
    sb = sel_cnt; ob = ovr_cnt;
    pulse_tick();
    repeat (20) @(negedge clk);
    check("t4_no_select", 32'(sel_cnt - sb), 32'd0);
    check("t4_not_busy", 32'(busy), 32'd0);
    check("t4_no_overrun", 32'(ovr_cnt - ob), 32'd0);
    configured = 1'b1;
    cb = cmd_q.size(); db = data_q.size();
    start_frame();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sensor_ss_n == 3'b101) begin ok = 1'b1; break; end
    end
    check("t4_gyro_selected", 32'(ok), 32'd1);
    configured = 1'b0;
    wait_frame_done("t4");
    check_frame("t4", cb, db, 8'h55);
    sb = sel_cnt;
    pulse_tick();
    repeat (20) @(negedge clk);
    check("t4_tick_ignored_sel", 32'(sel_cnt - sb), 32'd0);
    check("t4_tick_ignored_busy", 32'(busy), 32'd0);
    configured = 1'b1;

    // Test 5: tick in the frame_done cycle starts a second frame back to back.
    db = data_q.size(); ob = ovr_cnt; fb = done_cnt;
    start_frame();
    wait_frame_done("t5a");
    sample_tick = 1'b1;
    t_acc = $time + HALF;
    @(negedge clk);
    sample_tick = 1'b0;
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_frame_done("t5b");
    check("t5_second_cycles", 32'(frame_cycles(t_acc, t_seen)), 32'(FRAME_CYC));
    repeat (5) @(negedge clk);
    check("t5_strobes", 32'(data_q.size() - db), 32'd18);
    check("t5_overrun", 32'(ovr_cnt - ob), 32'd0);
    check("t5_frames", 32'(done_cnt - fb), 32'd2);

    // Test 6: address change mid-frame only affects the next frame.
    acc_add = 8'h55;
    cb = cmd_q.size(); db = data_q.size();
    start_frame();
    repeat (10) @(negedge clk);
    acc_add = 8'h33;
    wait_frame_done("t6a");
    check_frame("t6a", cb, db, 8'h55);
    cb = cmd_q.size(); db = data_q.size();
    start_frame();
    wait_frame_done("t6b");
    check_frame("t6b", cb, db, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
